// File: rtl/t03_wb_pkg.sv
// Shared Wishbone definitions for the t03 manager/subordinate pair.
// Contents: bus widths, responder state encoding, poison read value and a
// byte-lane merge helper used by the RAM array.
package t03_wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    // Returned for reads outside the RAM window so the manager always completes.
    localparam logic [WB_DAT_W-1:0] WB_BAD_DATA = 32'hBAD1_BAD1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } wb_state_e;

    // Replace only the bytes whose lane enable is set.
    function automatic logic [WB_DAT_W-1:0] wb_lane_merge(
        input logic [WB_DAT_W-1:0] old_word,
        input logic [WB_DAT_W-1:0] new_word,
        input logic [WB_SEL_W-1:0] sel
    );
        logic [WB_DAT_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < WB_SEL_W; b++) begin
            if (sel[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/t03_wishbone_subordinate_ram_if.sv
// Wishbone classic-cycle bus bundle.
// master modport: drives ADR_I/DAT_I/SEL_I/WE_I/STB_I/CYC_I, receives DAT_O/ACK_O.
// slave modport : the mirror image, used by the RAM responder.
interface t03_wishbone_subordinate_ram_if
    import t03_wb_pkg::*;
();
    logic [WB_ADR_W-1:0] ADR_I;
    logic [WB_DAT_W-1:0] DAT_I;
    logic [WB_SEL_W-1:0] SEL_I;
    logic                WE_I;
    logic                STB_I;
    logic                CYC_I;
    logic [WB_DAT_W-1:0] DAT_O;
    logic                ACK_O;

    modport master (
        output ADR_I, DAT_I, SEL_I, WE_I, STB_I, CYC_I,
        input  DAT_O, ACK_O
    );

    modport slave (
        input  ADR_I, DAT_I, SEL_I, WE_I, STB_I, CYC_I,
        output DAT_O, ACK_O
    );
endinterface

// File: rtl/t03_bytemask_ram.sv
// DEPTH x 32 register array with per-byte write mask.
// Ports: clk/rst_n (async active-low clear of every word), we/wr_idx/wr_data/
// wr_mask (synchronous masked write), rd_idx/rd_data (combinational read).
module t03_bytemask_ram
    import t03_wb_pkg::*;
#(
    parameter  int DEPTH = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [WB_DAT_W-1:0] wr_data,
    input  logic [WB_SEL_W-1:0] wr_mask,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [WB_DAT_W-1:0] rd_data
);

    logic [WB_DAT_W-1:0] mem_q [DEPTH];
    logic [WB_DAT_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[wr_idx] = wb_lane_merge(mem_q[wr_idx], wr_data, wr_mask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/t03_wishbone_subordinate_ram.sv
// Wishbone classic-cycle responder backed by a byte-maskable register RAM.
// Ports: CLK, nRST (async active-low), wb (slave modport: ADR_I, DAT_I, SEL_I,
// WE_I, STB_I, CYC_I in; DAT_O, ACK_O out).
//
// state | meaning
// IDLE  | waiting for CYC_I & STB_I; request fields are captured here
// WAIT  | counting down wait states; dropping CYC_I/STB_I aborts the cycle
// ACK   | one-cycle ACK_O pulse, read data on DAT_O
module t03_wishbone_subordinate_ram
    import t03_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3300_0000,
    parameter int          DEPTH       = 32,
    parameter int          WAIT_STATES = 1
) (
    input logic                            CLK,
    input logic                            nRST,
    t03_wishbone_subordinate_ram_if.slave  wb
);

    localparam int                  IDX_W = $clog2(DEPTH);
    localparam logic [3:0]          WS    = 4'(WAIT_STATES);
    localparam logic [WB_ADR_W-1:0] SPAN  = WB_ADR_W'(4 * DEPTH);

    wb_state_e           state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WB_DAT_W-1:0] wdat_q, wdat_d;
    logic [WB_SEL_W-1:0] sel_q, sel_d;
    logic                we_q, we_d;
    logic                inr_q, inr_d;
    logic                ack_q, ack_d;
    logic [WB_DAT_W-1:0] dato_q, dato_d;

    logic [WB_ADR_W-1:0] req_off;
    logic                req_inr;
    logic [IDX_W-1:0]    req_idx;
    logic                req_valid;

    logic                enter_ack;
    logic [IDX_W-1:0]    cur_idx;
    logic [WB_DAT_W-1:0] cur_wdat;
    logic [WB_SEL_W-1:0] cur_sel;
    logic                cur_we;
    logic                cur_inr;

    logic                ram_we;
    logic [WB_DAT_W-1:0] ram_rdata;

    // Unsigned offset compare covers both ends of the window: addresses below
    // BASE_ADDR wrap to large offsets.
    assign req_off   = wb.ADR_I - BASE_ADDR;
    assign req_inr   = (req_off < SPAN);
    assign req_idx   = req_off[IDX_W+1:2];
    assign req_valid = wb.CYC_I & wb.STB_I;

    // With zero wait states ACK is entered straight from IDLE, before the
    // request registers hold anything, so the live bus fields are used then.
    always_comb begin
        if (state_q == IDLE) begin
            cur_idx  = req_idx;
            cur_wdat = wb.DAT_I;
            cur_sel  = wb.SEL_I;
            cur_we   = wb.WE_I;
            cur_inr  = req_inr;
        end else begin
            cur_idx  = idx_q;
            cur_wdat = wdat_q;
            cur_sel  = sel_q;
            cur_we   = we_q;
            cur_inr  = inr_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdat_d    = wdat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        inr_d     = inr_q;
        ack_d     = 1'b0;
        dato_d    = '0;
        enter_ack = 1'b0;
        ram_we    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    idx_d  = req_idx;
                    wdat_d = wb.DAT_I;
                    sel_d  = wb.SEL_I;
                    we_d   = wb.WE_I;
                    inr_d  = req_inr;
                    cnt_d  = WS;
                    if (WAIT_STATES == 0) begin
                        state_d   = ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req_valid) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d   = ACK;
                        enter_ack = 1'b1;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_ack) begin
            ack_d = 1'b1;
            if (cur_we) begin
                ram_we = cur_inr;
            end else begin
                dato_d = cur_inr ? ram_rdata : WB_BAD_DATA;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            inr_q   <= 1'b0;
            ack_q   <= 1'b0;
            dato_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            inr_q   <= inr_d;
            ack_q   <= ack_d;
            dato_q  <= dato_d;
        end
    end

    t03_bytemask_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (CLK),
        .rst_n   (nRST),
        .we      (ram_we),
        .wr_idx  (cur_idx),
        .wr_data (cur_wdat),
        .wr_mask (cur_sel),
        .rd_idx  (cur_idx),
        .rd_data (ram_rdata)
    );

    assign wb.ACK_O = ack_q;
    assign wb.DAT_O = dato_q;

endmodule

// File: tb/tb_t03_wishbone_subordinate_ram.sv
// Bench for the Wishbone RAM responder: two instances (1 and 3 wait states)
// share the address/data/strobe lines and have separate CYC_I, so each
// transfer targets exactly one of them. A word array per instance holds the
// expected memory contents.
module tb_t03_wishbone_subordinate_ram;

    localparam logic [31:0] BASE  = 32'h3300_0000;
    localparam int          DEPTH = 32;
    localparam int          WS1   = 1;
    localparam int          WS3   = 3;
    localparam logic [31:0] BAD   = 32'hBAD1_BAD1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] adr_s = '0;
    logic [31:0] dat_s = '0;
    logic [3:0]  sel_s = '0;
    logic        we_s  = 1'b0;
    logic        stb_s = 1'b0;
    logic        cyc1  = 1'b0;
    logic        cyc3  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m1 [DEPTH];
    logic [31:0] m3 [DEPTH];

    always #5 clk = ~clk;

    t03_wishbone_subordinate_ram_if bus1 ();
    t03_wishbone_subordinate_ram_if bus3 ();

    assign bus1.ADR_I = adr_s;
    assign bus1.DAT_I = dat_s;
    assign bus1.SEL_I = sel_s;
    assign bus1.WE_I  = we_s;
    assign bus1.STB_I = stb_s;
    assign bus1.CYC_I = cyc1;
    assign bus3.ADR_I = adr_s;
    assign bus3.DAT_I = dat_s;
    assign bus3.SEL_I = sel_s;
    assign bus3.WE_I  = we_s;
    assign bus3.STB_I = stb_s;
    assign bus3.CYC_I = cyc3;

    t03_wishbone_subordinate_ram #(
        .BASE_ADDR   (BASE),
        .DEPTH       (DEPTH),
        .WAIT_STATES (WS1)
    ) dut (
        .CLK  (clk),
        .nRST (rst_n),
        .wb   (bus1)
    );

    t03_wishbone_subordinate_ram #(
        .BASE_ADDR   (BASE),
        .DEPTH       (DEPTH),
        .WAIT_STATES (WS3)
    ) dut3 (
        .CLK  (clk),
        .nRST (rst_n),
        .wb   (bus3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] sel);
        logic [31:0] w;
        w = old_w;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) w[8*b +: 8] = new_w[8*b +: 8];
        end
        return w;
    endfunction

    // One complete classic cycle against instance d (1 or 3); checks latency,
    // data and the single-cycle ACK, then updates the reference memory.
    task automatic bus_op(input int d, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic we, output logic [31:0] rd);
        logic [31:0] off;
        logic [31:0] exp;
        logic        inr;
        logic        got_ack;
        int          idx;
        int          n;
        int          ws;
        off = adr - BASE;
        inr = (off < 32'(4 * DEPTH));
        idx = inr ? int'(off >> 2) : 0;
        ws  = (d == 1) ? WS1 : WS3;
        exp = 32'h0;
        if (!we) begin
            if (!inr)        exp = BAD;
            else if (d == 1) exp = m1[idx];
            else             exp = m3[idx];
        end

        adr_s = adr; dat_s = dat; sel_s = sel; we_s = we; stb_s = 1'b1;
        if (d == 1) cyc1 = 1'b1; else cyc3 = 1'b1;

        n = 0;
        got_ack = 1'b0;
        while (!got_ack && n < 40) begin
            @(posedge clk); #1;
            n++;
            got_ack = (d == 1) ? bus1.ACK_O : bus3.ACK_O;
        end
        check_eq(we ? "wr_ack_latency" : "rd_ack_latency", 32'(n), 32'(ws + 1));
        rd = (d == 1) ? bus1.DAT_O : bus3.DAT_O;
        check_eq(we ? "wr_dat_o_zero" : "rd_data", rd, exp);

        if (we && inr) begin
            if (d == 1) m1[idx] = merge(m1[idx], dat, sel);
            else        m3[idx] = merge(m3[idx], dat, sel);
        end

        stb_s = 1'b0; cyc1 = 1'b0; cyc3 = 1'b0;
        @(posedge clk); #1;
        check_eq("ack_single_cycle", {31'h0, (d == 1) ? bus1.ACK_O : bus3.ACK_O}, 32'h0);
        check_eq("dat_o_after_ack", (d == 1) ? bus1.DAT_O : bus3.DAT_O, 32'h0);
    endtask

    task automatic sweep(input int d);
        logic [31:0] rd;
        for (int i = 0; i < DEPTH; i++) begin
            bus_op(d, BASE + 32'(4 * i), 32'h0, 4'hF, 1'b0, rd);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] adr;
        int          d;
        int          r;

        for (int i = 0; i < DEPTH; i++) begin m1[i] = '0; m3[i] = '0; end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_ack1", {31'h0, bus1.ACK_O}, 32'h0);
        check_eq("reset_dat1", bus1.DAT_O, 32'h0);
        check_eq("reset_ack3", {31'h0, bus3.ACK_O}, 32'h0);
        check_eq("reset_dat3", bus3.DAT_O, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Read after reset, then full write/readback
        bus_op(1, BASE + 32'h10, 32'h0, 4'hF, 1'b0, rd);
        check_eq("reset_read_zero", rd, 32'h0);
        bus_op(1, BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, 1'b1, rd);
        bus_op(1, BASE + 32'h4, 32'h0, 4'hF, 1'b0, rd);
        check_eq("full_readback", rd, 32'hDEAD_BEEF);

        // Byte lanes
        bus_op(1, BASE + 32'h4, 32'h1122_3344, 4'b0101, 1'b1, rd);
        bus_op(1, BASE + 32'h4, 32'h0, 4'hF, 1'b0, rd);
        check_eq("lane_readback", rd, 32'hDE22_BE44);
        bus_op(1, BASE + 32'h4, 32'h5566_7788, 4'b0000, 1'b1, rd);
        bus_op(1, BASE + 32'h4, 32'h0, 4'h3, 1'b0, rd);
        check_eq("sel0_unchanged", rd, 32'hDE22_BE44);

        // Out of range
        bus_op(1, BASE + 32'(4 * DEPTH), 32'h0, 4'hF, 1'b0, rd);
        check_eq("oor_read_bad", rd, BAD);
        bus_op(1, BASE - 32'h4, 32'hFFFF_FFFF, 4'hF, 1'b1, rd);
        sweep(1);

        // STB without CYC is ignored
        adr_s = BASE; we_s = 1'b1; dat_s = 32'hFFFF_FFFF; sel_s = 4'hF; stb_s = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check_eq("stb_no_cyc_ack", {31'h0, bus1.ACK_O}, 32'h0);
        end
        stb_s = 1'b0;
        @(posedge clk); #1;

        // Abort on the 3-wait-state instance
        bus_op(3, BASE, 32'h1234_5678, 4'hF, 1'b1, rd);
        adr_s = BASE; dat_s = 32'hA5A5_A5A5; sel_s = 4'hF; we_s = 1'b1; stb_s = 1'b1; cyc3 = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_ack_w0", {31'h0, bus3.ACK_O}, 32'h0);
        @(posedge clk); #1;
        cyc3 = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            check_eq("abort_no_ack", {31'h0, bus3.ACK_O}, 32'h0);
        end
        stb_s = 1'b0;
        bus_op(3, BASE, 32'h0, 4'hF, 1'b0, rd);
        check_eq("abort_readback", rd, 32'h1234_5678);

        // Randomized back-to-back traffic on both instances
        for (int k = 0; k < 120; k++) begin
            d = ($urandom_range(0, 1) == 0) ? 1 : 3;
            r = int'($urandom_range(0, 9));
            if (r < 8)       adr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
            else if (r == 8) adr = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 7));
            else             adr = BASE - 32'(4 * $urandom_range(1, 8));
            bus_op(d, adr, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), rd);
        end
        sweep(1);
        sweep(3);

        // Reset during WAIT abandons the transfer and clears the RAM
        adr_s = BASE + 32'h8; dat_s = 32'hCAFE_F00D; sel_s = 4'hF; we_s = 1'b1; stb_s = 1'b1; cyc1 = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_ack", {31'h0, bus1.ACK_O}, 32'h0);
        @(posedge clk); #1;
        check_eq("rst_mid_ack_next", {31'h0, bus1.ACK_O}, 32'h0);
        check_eq("rst_mid_dat", bus1.DAT_O, 32'h0);
        stb_s = 1'b0; cyc1 = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin m1[i] = '0; m3[i] = '0; end
        @(posedge clk); #1;
        sweep(1);
        sweep(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
